// File: rtl/sensor_poll_scheduler_if.sv
// Sensor-channel and UART-transmit bundle between the poll scheduler (master)
// and the per-sensor FIFO channels / UART transmitter (slave).
interface sensor_poll_scheduler_if #(
  parameter int unsigned N_SENSORS  = 8,
  parameter int unsigned DATA_DEPTH = 8
) ();
  logic [N_SENSORS-1:0]            trig;
  logic [N_SENSORS-1:0]            fifo_valid;
  logic [N_SENSORS*DATA_DEPTH-1:0] fifo_data;
  logic [N_SENSORS-1:0]            fifo_pop;
  logic [DATA_DEPTH-1:0]           tx_data;
  logic                            tx_valid;
  logic                            tx_ready;

  modport master (
    output trig, fifo_pop, tx_data, tx_valid,
    input  fifo_valid, fifo_data, tx_ready
  );

  modport slave (
    input  trig, fifo_pop, tx_data, tx_valid,
    output fifo_valid, fifo_data, tx_ready
  );
endinterface

// File: rtl/sensor_poll_scheduler.sv
// Periodic poll scheduler: on each period tick, walks the enabled sensor
// channels in ascending order, triggers a conversion, waits for FIFO data and
// streams a header byte plus the sample bytes (or an error byte on timeout)
// through the shared UART transmit handshake.
module sensor_poll_scheduler #(
  parameter int unsigned N_SENSORS        = 8,
  parameter int unsigned CH_BITS          = 3,
  parameter int unsigned DATA_DEPTH       = 8,
  parameter int unsigned PERIOD_CYCLES    = 26000000,
  parameter int unsigned PERIOD_BITS      = 32,
  parameter int unsigned BYTES_PER_SAMPLE = 2,
  parameter int unsigned HEADER_BASE      = 97,
  parameter int unsigned ERR_BYTE         = 238,
  parameter int unsigned TIMEOUT_CYCLES   = 65535,
  parameter int unsigned TIMEOUT_BITS     = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_SENSORS-1:0]      i_chan_en,
  sensor_poll_scheduler_if.master   io_bus,
  output logic                      o_busy,
  output logic [CH_BITS-1:0]        o_cur_ch,
  output logic [N_SENSORS-1:0]      o_err,
  input  logic                      i_err_clr,
  output logic                      o_overrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_TRIG = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_HDR  = 3'd4;
  localparam logic [2:0] S_DATA = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;
  localparam logic [2:0] S_NEXT = 3'd7;

  localparam int unsigned CNT_BITS = $clog2(BYTES_PER_SAMPLE + 1);

  localparam logic [CH_BITS-1:0]      LAST_CH    = CH_BITS'(N_SENSORS - 1);
  localparam logic [PERIOD_BITS-1:0]  PER_RELOAD = PERIOD_BITS'(PERIOD_CYCLES - 1);
  localparam logic [TIMEOUT_BITS-1:0] TO_LAST    = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_BITS-1:0]     CNT_LAST   = CNT_BITS'(BYTES_PER_SAMPLE - 1);
  localparam logic [DATA_DEPTH-1:0]   HDR_BASE_B = DATA_DEPTH'(HEADER_BASE);
  localparam logic [DATA_DEPTH-1:0]   ERR_B      = DATA_DEPTH'(ERR_BYTE);

  logic [2:0]              r_state,     w_state_n;
  logic [CH_BITS-1:0]      r_ch,        w_ch_n;
  logic [N_SENSORS-1:0]    r_mask,      w_mask_n;
  logic                    r_pending,   w_pending_n;
  logic                    r_overrun,   w_overrun_n;
  logic [PERIOD_BITS-1:0]  r_period,    w_period_n;
  logic [TIMEOUT_BITS-1:0] r_to,        w_to_n;
  logic [CNT_BITS-1:0]     r_cnt,       w_cnt_n;
  logic                    r_errflag,   w_errflag_n;
  logic [N_SENSORS-1:0]    r_err,       w_err_n;
  // r_held: a data byte was offered but not yet accepted, so it must not drop.
  logic                    r_held,      w_held_n;
  logic [DATA_DEPTH-1:0]   r_hold_data, w_hold_data_n;

  logic                    w_tick;
  logic                    w_xfer;
  logic                    w_fifo_vld;
  logic [DATA_DEPTH-1:0]   w_head;
  logic                    w_tx_valid;
  logic [DATA_DEPTH-1:0]   w_tx_data;
  logic [N_SENSORS-1:0]    w_trig;
  logic [N_SENSORS-1:0]    w_pop;

  assign w_tick     = (r_period == '0);
  assign w_fifo_vld = io_bus.fifo_valid[r_ch];
  assign w_head     = io_bus.fifo_data[r_ch * DATA_DEPTH +: DATA_DEPTH];
  assign w_xfer     = w_tx_valid & io_bus.tx_ready;

  // Decode per-state outputs toward the channels and the UART.
  always_comb begin
    w_tx_valid = 1'b0;
    w_tx_data  = '0;
    w_trig     = '0;
    w_pop      = '0;
    case (r_state)
      S_TRIG: w_trig[r_ch] = 1'b1;
      S_HDR: begin
        w_tx_valid = 1'b1;
        w_tx_data  = HDR_BASE_B + DATA_DEPTH'(r_ch);
      end
      S_DATA: begin
        w_tx_valid   = r_held | w_fifo_vld;
        w_tx_data    = r_held ? r_hold_data : w_head;
        w_pop[r_ch]  = w_tx_valid & io_bus.tx_ready;
      end
      S_ERR: begin
        w_tx_valid = 1'b1;
        w_tx_data  = ERR_B;
      end
      default: ;
    endcase
  end

  assign io_bus.tx_valid = w_tx_valid;
  assign io_bus.tx_data  = w_tx_data;
  assign io_bus.trig     = w_trig;
  assign io_bus.fifo_pop = w_pop;

  // Next-state logic: period timer, tick bookkeeping, round sequencing.
  always_comb begin
    w_state_n     = r_state;
    w_ch_n        = r_ch;
    w_mask_n      = r_mask;
    w_to_n        = r_to;
    w_cnt_n       = r_cnt;
    w_errflag_n   = r_errflag;
    w_held_n      = r_held;
    w_hold_data_n = r_hold_data;
    w_period_n    = w_tick ? PER_RELOAD : r_period - 1'b1;
    // Only one tick may be queued; a tick arriving with one already queued is lost.
    w_overrun_n   = w_tick & r_pending;
    w_pending_n   = r_pending | w_tick;
    // Set (below) wins over clear.
    w_err_n       = i_err_clr ? '0 : r_err;

    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_pending_n = 1'b0;
          if (|i_chan_en) begin
            w_mask_n  = i_chan_en;
            w_ch_n    = '0;
            w_state_n = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (r_mask[r_ch])         w_state_n = S_TRIG;
        else if (r_ch == LAST_CH) w_state_n = S_IDLE;
        else                      w_ch_n    = r_ch + 1'b1;
      end
      S_TRIG: begin
        w_to_n    = '0;
        w_state_n = S_WAIT;
      end
      S_WAIT: begin
        if (w_fifo_vld) begin
          w_state_n = S_HDR;
        end else if (r_to == TO_LAST) begin
          w_err_n[r_ch] = 1'b1;
          w_errflag_n   = 1'b1;
          w_state_n     = S_HDR;
        end else begin
          w_to_n = r_to + 1'b1;
        end
      end
      S_HDR: begin
        if (w_xfer) begin
          w_cnt_n   = '0;
          w_to_n    = '0;
          w_held_n  = 1'b0;
          w_state_n = r_errflag ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        if (w_xfer) begin
          w_held_n = 1'b0;
          w_to_n   = '0;
          w_cnt_n  = r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) w_state_n = S_NEXT;
        end else if (w_tx_valid) begin
          w_held_n      = 1'b1;
          w_hold_data_n = w_tx_data;
        end else if (r_to == TO_LAST) begin
          w_err_n[r_ch] = 1'b1;
          w_state_n     = S_ERR;
        end else begin
          w_to_n = r_to + 1'b1;
        end
      end
      S_ERR: begin
        if (w_xfer) w_state_n = S_NEXT;
      end
      S_NEXT: begin
        w_errflag_n = 1'b0;
        if (r_ch == LAST_CH) begin
          w_state_n = S_IDLE;
        end else begin
          w_ch_n    = r_ch + 1'b1;
          w_state_n = S_SCAN;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_mask      <= '0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
      r_period    <= PER_RELOAD;
      r_to        <= '0;
      r_cnt       <= '0;
      r_errflag   <= 1'b0;
      r_err       <= '0;
      r_held      <= 1'b0;
      r_hold_data <= '0;
    end else begin
      r_state     <= w_state_n;
      r_ch        <= w_ch_n;
      r_mask      <= w_mask_n;
      r_pending   <= w_pending_n;
      r_overrun   <= w_overrun_n;
      r_period    <= w_period_n;
      r_to        <= w_to_n;
      r_cnt       <= w_cnt_n;
      r_errflag   <= w_errflag_n;
      r_err       <= w_err_n;
      r_held      <= w_held_n;
      r_hold_data <= w_hold_data_n;
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_cur_ch  = o_busy ? r_ch : '0;
  assign o_err     = r_err;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler: FIFO model for channels 0 and 2,
// scoreboard queue of expected UART bytes, checks via immediate assertions.
module tb_sensor_poll_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] chan_en;
  logic       err_clr;
  logic       busy;
  logic [2:0] cur_ch;
  logic [7:0] err;
  logic       overrun;

  always #5 clk = ~clk;

  sensor_poll_scheduler_if #(.N_SENSORS(8), .DATA_DEPTH(8)) bus ();

  sensor_poll_scheduler #(
    .N_SENSORS(8), .CH_BITS(3), .DATA_DEPTH(8), .PERIOD_CYCLES(100), .PERIOD_BITS(32),
    .BYTES_PER_SAMPLE(2), .HEADER_BASE(97), .ERR_BYTE(238), .TIMEOUT_CYCLES(20),
    .TIMEOUT_BITS(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_chan_en(chan_en), .io_bus(bus), .o_busy(busy),
    .o_cur_ch(cur_ch), .o_err(err), .i_err_clr(err_clr), .o_overrun(overrun)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n = 0;
  int n_pop = 0;
  int n_ovr = 0;
  int n_xfer = 0;
  int last_xfer_cyc = 0;
  int last_trig_cyc = 0;
  logic [7:0] sb[$];
  logic [7:0] fq0[$];
  logic [7:0] fq2[$];
  logic [7:0] trig_q[$];
  logic [2:0] ch_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_valid = '0;
    bus.fifo_data  = '0;
    if (fq0.size() > 0) begin
      bus.fifo_valid[0]    = 1'b1;
      bus.fifo_data[7:0]   = fq0[0];
    end
    if (fq2.size() > 0) begin
      bus.fifo_valid[2]    = 1'b1;
      bus.fifo_data[23:16] = fq2[0];
    end
  endtask

  // One clock: observe at negedge, apply FIFO pops just after the posedge.
  task automatic cyc();
    logic [7:0] p;
    @(negedge clk);
    cyc_n++;
    if (bus.tx_valid && bus.tx_ready) begin
      n_xfer++;
      last_xfer_cyc = cyc_n;
      n_checks++;
      assert (sb.size() != 0) else begin
        n_errors++;
        $error("FAIL tx_unexpected: observed byte %0h, expected no transfer", bus.tx_data);
      end
      if (sb.size() != 0) chk("tx_byte", {24'b0, bus.tx_data}, {24'b0, sb.pop_front()});
    end
    if (|bus.trig) begin
      trig_q.push_back(bus.trig);
      ch_q.push_back(cur_ch);
      last_trig_cyc = cyc_n;
    end
    if (overrun) n_ovr++;
    p = bus.fifo_pop;
    n_pop += $countones(p);
    @(posedge clk);
    #1;
    if (p[0] && fq0.size() > 0) void'(fq0.pop_front());
    if (p[2] && fq2.size() > 0) void'(fq2.pop_front());
    drive_fifo();
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int k = 0;
    while (busy !== lvl && k < budget) begin
      cyc();
      k++;
    end
    chk(tag, {31'b0, busy}, {31'b0, lvl});
  endtask

  initial begin
    int k;
    int start;
    logic ok;
    chan_en = '0;
    err_clr = 1'b0;
    bus.tx_ready = 1'b0;
    drive_fifo();

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_tx_valid", {31'b0, bus.tx_valid}, 0);
    chk("rst_tx_data", {24'b0, bus.tx_data}, 0);
    chk("rst_trig", {24'b0, bus.trig}, 0);
    chk("rst_pop", {24'b0, bus.fifo_pop}, 0);
    chk("rst_err", {24'b0, err}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);
    chk("rst_cur_ch", {29'b0, cur_ch}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Two-channel round, UART always ready.
    chan_en = 8'b0000_0101;
    bus.tx_ready = 1'b1;
    fq0.push_back(8'h19); fq0.push_back(8'h80);
    fq2.push_back(8'h1A); fq2.push_back(8'h40);
    drive_fifo();
    sb.push_back(8'd97); sb.push_back(8'h19); sb.push_back(8'h80);
    sb.push_back(8'd99); sb.push_back(8'h1A); sb.push_back(8'h40);
    n_pop = 0;
    wait_busy(1'b1, 150, "t1_start");
    wait_busy(1'b0, 90, "t1_done_before_next_tick");
    chk("t1_sb_drained", sb.size(), 0);
    chk("t1_pops", n_pop, 4);
    chk("t1_trig_count", trig_q.size(), 2);
    if (trig_q.size() == 2) begin
      chk("t1_trig_first", {24'b0, trig_q[0]}, 32'h01);
      chk("t1_trig_second", {24'b0, trig_q[1]}, 32'h04);
      chk("t1_cur_ch_second", {29'b0, ch_q[1]}, 2);
    end

    // Silent channel: timeout, header + error byte, sticky flag, clear.
    chan_en = 8'b0000_0010;
    trig_q.delete(); ch_q.delete();
    sb.push_back(8'd98); sb.push_back(8'd238);
    n_pop = 0;
    wait_busy(1'b1, 150, "t2_start");
    wait_busy(1'b0, 60, "t2_done");
    chk("t2_sb_drained", sb.size(), 0);
    chk("t2_no_pop", n_pop, 0);
    chk("t2_trig_count", trig_q.size(), 1);
    if (trig_q.size() == 1) chk("t2_trig_ch1", {24'b0, trig_q[0]}, 32'h02);
    // TRIG at t, 20 WAIT cycles, header at t+21, error byte at t+22.
    chk("t2_err_byte_latency", last_xfer_cyc - last_trig_cyc, 22);
    chk("t2_err_flag", {24'b0, err}, 32'h02);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t2_err_cleared", {24'b0, err}, 0);

    // UART stalled 50 cycles on the header byte.
    chan_en = 8'b0000_0001;
    bus.tx_ready = 1'b0;
    fq0.push_back(8'h55); fq0.push_back(8'hAA);
    drive_fifo();
    sb.push_back(8'd97); sb.push_back(8'h55); sb.push_back(8'hAA);
    n_pop = 0;
    k = 0;
    while (bus.tx_valid !== 1'b1 && k < 150) begin cyc(); k++; end
    chk("t3_hdr_offered", {31'b0, bus.tx_valid}, 1);
    ok = 1'b1;
    repeat (50) begin
      if (!(bus.tx_valid === 1'b1 && bus.tx_data === 8'd97)) ok = 1'b0;
      cyc();
    end
    chk("t3_hdr_stable", {31'b0, ok}, 1);
    chk("t3_no_pop_during_stall", n_pop, 0);
    bus.tx_ready = 1'b1;
    wait_busy(1'b0, 40, "t3_done");
    chk("t3_sb_drained", sb.size(), 0);
    chk("t3_pops", n_pop, 2);

    // Slow round across three ticks: one queued, one dropped.
    fq0.push_back(8'h11); fq0.push_back(8'h22); fq0.push_back(8'h33); fq0.push_back(8'h44);
    drive_fifo();
    bus.tx_ready = 1'b0;
    sb.push_back(8'd97); sb.push_back(8'h11); sb.push_back(8'h22);
    sb.push_back(8'd97); sb.push_back(8'h33); sb.push_back(8'h44);
    n_ovr = 0;
    wait_busy(1'b1, 150, "t4_start");
    repeat (250) cyc();
    chk("t4_overrun_once", n_ovr, 1);
    bus.tx_ready = 1'b1;
    wait_busy(1'b0, 20, "t4_round1_done");
    k = 0;
    while (busy !== 1'b1 && k < 10) begin cyc(); k++; end
    chk("t4_back_to_back_gap", k, 1);
    chan_en = 8'h00;
    wait_busy(1'b0, 40, "t4_round2_done");
    chk("t4_sb_drained", sb.size(), 0);

    // Empty mask across several ticks: nothing happens, nothing queued.
    trig_q.delete(); ch_q.delete();
    start = n_xfer;
    ok = 1'b1;
    repeat (250) begin
      cyc();
      if (busy !== 1'b0) ok = 1'b0;
    end
    chk("t5_never_busy", {31'b0, ok}, 1);
    chk("t5_no_trig", trig_q.size(), 0);
    chk("t5_no_tx", n_xfer - start, 0);
    chk("t5_no_new_overrun", n_ovr, 1);

    // Reset in DATA after the first sample byte, then a fresh round.
    chan_en = 8'b0000_0001;
    fq0.push_back(8'h77); fq0.push_back(8'h88); fq0.push_back(8'h99);
    drive_fifo();
    sb.push_back(8'd97); sb.push_back(8'h77);
    start = n_pop;
    k = 0;
    while (n_pop == start && k < 150) begin cyc(); k++; end
    chk("t6_first_pop", n_pop - start, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", {31'b0, busy}, 0);
    chk("t6_rst_tx_valid", {31'b0, bus.tx_valid}, 0);
    chk("t6_rst_tx_data", {24'b0, bus.tx_data}, 0);
    chk("t6_rst_pop", {24'b0, bus.fifo_pop}, 0);
    chk("t6_rst_cur_ch", {29'b0, cur_ch}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_sb_before_restart", sb.size(), 0);
    sb.push_back(8'd97); sb.push_back(8'h88); sb.push_back(8'h99);
    trig_q.delete(); ch_q.delete();
    wait_busy(1'b1, 150, "t6_restart");
    wait_busy(1'b0, 60, "t6_done");
    chk("t6_sb_drained", sb.size(), 0);
    chk("t6_trig_count", trig_q.size(), 1);
    if (trig_q.size() == 1) chk("t6_trig_ch0", {24'b0, trig_q[0]}, 32'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
